// File: rtl/decoder_pipe.sv
// Binary-to-one-hot decoder behind a 2-entry skid FIFO (head = output register, tail = skid register).
// Handshake outputs depend only on registered state, so upstream and downstream timing stay decoupled.
module decoder_pipe #(
    parameter int BIN_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BIN_WIDTH-1:0]      bin_in,
    input  logic                      enable,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [(2**BIN_WIDTH)-1:0] dec_out,
    output logic [1:0]                occupancy
);

    localparam int OUT_WIDTH = 2 ** BIN_WIDTH;

    generate
        if (BIN_WIDTH < 1 || BIN_WIDTH > 8) begin : g_bad_width
            $error("decoder_pipe: BIN_WIDTH must be in 1..8");
        end
    endgenerate

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // The shift operand is OUT_WIDTH wide so the top code still lands on the MSB.
    function automatic logic [OUT_WIDTH-1:0] onehot_word(
        input logic                 en,
        input logic [BIN_WIDTH-1:0] code
    );
        logic [OUT_WIDTH-1:0] one;
        one = {{(OUT_WIDTH-1){1'b0}}, 1'b1};
        onehot_word = en ? (one << code) : '0;
    endfunction

    state_t               state, state_nxt;
    logic [OUT_WIDTH-1:0] head_p1, head_nxt;
    logic [OUT_WIDTH-1:0] tail_p1, tail_nxt;
    logic [OUT_WIDTH-1:0] word_p0;
    logic                 accept;
    logic                 pop;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign occupancy = state;
    assign dec_out   = head_p1;

    assign accept  = in_valid && in_ready;
    assign pop     = out_valid && out_ready;
    assign word_p0 = onehot_word(enable, bin_in);

    // Input stage -> FIFO: head is cleared whenever it is vacated so dec_out reads 0 when idle.
    always_comb begin
        state_nxt = state;
        head_nxt  = head_p1;
        tail_nxt  = tail_p1;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    head_nxt  = word_p0;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    head_nxt = word_p0;
                end else if (accept) begin
                    state_nxt = TWO;
                    tail_nxt  = word_p0;
                end else if (pop) begin
                    state_nxt = EMPTY;
                    head_nxt  = '0;
                end
            end
            TWO: begin
                if (pop) begin
                    state_nxt = ONE;
                    head_nxt  = tail_p1;
                    tail_nxt  = '0;
                end
            end
            default: begin
                state_nxt = EMPTY;
                head_nxt  = '0;
                tail_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            head_p1 <= '0;
            tail_p1 <= '0;
        end else begin
            state   <= state_nxt;
            head_p1 <= head_nxt;
            tail_p1 <= tail_nxt;
        end
    end

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed and randomized checks of decoder_pipe at BIN_WIDTH 1, 4 and 8 sharing one handshake stream.
module tb_decoder_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic       enable;
    logic [7:0] bin8;

    logic         rdy1, vld1, rdy4, vld4, rdy8, vld8;
    logic [1:0]   dec1;
    logic [15:0]  dec4;
    logic [255:0] dec8;
    logic [1:0]   occ1, occ4, occ8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decoder_pipe #(.BIN_WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .bin_in(bin8[0]), .enable(enable), .out_valid(vld1),
        .out_ready(out_ready), .dec_out(dec1), .occupancy(occ1)
    );
    decoder_pipe #(.BIN_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
        .bin_in(bin8[3:0]), .enable(enable), .out_valid(vld4),
        .out_ready(out_ready), .dec_out(dec4), .occupancy(occ4)
    );
    decoder_pipe #(.BIN_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
        .bin_in(bin8), .enable(enable), .out_valid(vld8),
        .out_ready(out_ready), .dec_out(dec8), .occupancy(occ8)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] model_word(input logic en, input int code);
        logic [255:0] one;
        one = 256'd1;
        return en ? (one << code) : 256'd0;
    endfunction

    logic [255:0] q1[$];
    logic [255:0] q4[$];
    logic [255:0] q8[$];

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; enable = 1'b0; bin8 = 8'd0;
        tick();
        tick();
        chk("reset_out_valid", vld4, 0);
        chk("reset_dec_out",   dec4, 0);
        chk("reset_occupancy", occ4, 0);
        chk("reset_in_ready",  rdy4, 1);
        rst = 1'b0;

        // single word, latency one
        out_ready = 1'b1; in_valid = 1'b1; bin8 = 8'd5; enable = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bin5_valid", vld4, 1);
        chk("bin5_dec",   dec4, 16'h0020);
        chk("bin5_occ",   occ4, 1);
        tick();
        chk("bin5_drained_valid", vld4, 0);
        chk("bin5_drained_dec",   dec4, 0);

        // top code then disabled word
        in_valid = 1'b1; bin8 = 8'd15; enable = 1'b1;
        tick();
        bin8 = 8'd3; enable = 1'b0;
        chk("bin15_dec",   dec4, 16'h8000);
        chk("bin15_valid", vld4, 1);
        tick();
        in_valid = 1'b0; bin8 = 8'd9; enable = 1'b1;
        chk("disabled_dec",   dec4, 16'h0000);
        chk("disabled_valid", vld4, 1);
        chk("disabled_occ",   occ4, 1);
        tick();
        chk("disabled_drained_valid", vld4, 0);

        // backpressure fills the FIFO
        out_ready = 1'b0; in_valid = 1'b1; bin8 = 8'd1;
        tick();
        chk("bp1_occ",   occ4, 1);
        chk("bp1_ready", rdy4, 1);
        chk("bp1_dec",   dec4, 16'h0002);
        bin8 = 8'd2;
        tick();
        chk("bp2_occ",   occ4, 2);
        chk("bp2_ready", rdy4, 0);
        chk("bp2_dec",   dec4, 16'h0002);
        bin8 = 8'd3;
        tick();
        chk("bp3_occ", occ4, 2);
        chk("bp3_dec", dec4, 16'h0002);
        out_ready = 1'b1;
        tick();
        chk("pop_two_occ",   occ4, 1);
        chk("pop_two_dec",   dec4, 16'h0004);
        chk("pop_two_ready", rdy4, 1);
        tick();
        in_valid = 1'b0;
        chk("same_edge_occ", occ4, 1);
        chk("same_edge_dec", dec4, 16'h0008);
        tick();
        chk("bp_drained_valid", vld4, 0);

        // reset in state TWO discards both words
        out_ready = 1'b0; in_valid = 1'b1; bin8 = 8'd6;
        tick();
        bin8 = 8'd7;
        tick();
        chk("pre_rst_occ", occ4, 2);
        rst = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_two_valid", vld4, 0);
        chk("rst_two_dec",   dec4, 0);
        chk("rst_two_occ",   occ4, 0);
        chk("rst_two_ready", rdy4, 1);
        tick();
        chk("rst_two_after_valid", vld4, 0);
        chk("rst_two_after_dec",   dec4, 0);

        // randomized traffic with scoreboards for all three widths
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic acc, pp;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            enable    = ($urandom_range(0, 7) != 0);
            bin8      = 8'($urandom);
            acc = in_valid && rdy4;
            pp  = vld4 && out_ready;
            if (!$onehot0(dec1) || !$onehot0(dec4) || !$onehot0(dec8)) begin
                chk("rand_onehot0", {dec1, dec4}, 0);
            end
            if (occ4 != 2'(q4.size())) chk("rand_occ4", occ4, q4.size());
            if (occ1 != occ4 || occ8 != occ4) chk("rand_occ_align", {occ1, occ8}, {occ4, occ4});
            if (pp) begin
                if (q4.size() == 0) begin
                    chk("rand_underflow", vld4, 0);
                end else begin
                    chk("rand_w1", dec1, q1.pop_front());
                    chk("rand_w4", dec4, q4.pop_front());
                    chk("rand_w8", dec8, q8.pop_front());
                end
            end
            if (acc) begin
                q1.push_back(model_word(enable, int'(bin8[0])));
                q4.push_back(model_word(enable, int'(bin8[3:0])));
                q8.push_back(model_word(enable, int'(bin8)));
            end
            tick();
        end
        chk("rand_final_occ", occ4, q4.size());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_pipe.md
DECODER_PIPE -- requirements
Module: decoder_pipe

Interface
REQ-001 Parameter BIN_WIDTH, default 4, binary input width; legal range 1..8.
REQ-002 Derived width OUT_WIDTH = 2**BIN_WIDTH is the one-hot output width; it SHALL be a localparam, not overridable.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  producer presents a word.
REQ-006 in_ready  output  1  block can accept a word; registered.
REQ-007 bin_in  input  BIN_WIDTH  binary code to decode.
REQ-008 enable  input  1  decode enable, sampled together with bin_in.
REQ-009 out_valid  output  1  dec_out holds a decoded word; registered.
REQ-010 out_ready  input  1  consumer accepts the word.
REQ-011 dec_out  output  OUT_WIDTH  one-hot decoded word; registered.
REQ-012 occupancy  output  2  number of buffered words, 0..2.

Function
REQ-013 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; pop SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-014 An accepted word SHALL be stored as enable ? (1 << bin_in) : 0; exactly one bit SHALL be set when enable=1, and all bits SHALL be 0 when enable=0.
REQ-015 The block SHALL buffer words in a 2-entry FIFO (head = output register, tail = skid register), with states EMPTY (occ 0), ONE (occ 1), and TWO (occ 2).
REQ-016 EMPTY: accept -> ONE, with the word loaded into head.
REQ-017 ONE: accept only -> TWO (word into tail); pop only -> EMPTY; accept and pop on the same edge -> ONE, with the new word into head.
REQ-018 TWO: pop -> ONE, with tail moved to head; accept is impossible in TWO.
REQ-019 Latency SHALL be 1 cycle: a word accepted on edge k SHALL appear on dec_out with out_valid=1 immediately after edge k when the FIFO was empty.
REQ-020 in_ready SHALL equal (state != TWO) as a registered value; it SHALL have no combinational path from out_ready or in_valid.
REQ-021 After a pop from TWO, in_ready SHALL rise after that edge; no accept SHALL occur on the pop edge.
REQ-022 out_valid SHALL equal (state != EMPTY), and occupancy SHALL equal the state encoding 0/1/2.
REQ-023 While out_valid=1 and out_ready=0, dec_out and out_valid SHALL hold stable.
REQ-024 Words SHALL leave in acceptance order; no word SHALL be dropped or duplicated.
REQ-025 bin_in and enable SHALL be ignored when no accept occurs.
REQ-026 dec_out SHALL read 0 whenever out_valid=0.
REQ-027 The stored word width SHALL be OUT_WIDTH, and the shift SHALL be evaluated at OUT_WIDTH with no truncation for bin_in = 2**BIN_WIDTH-1.

Reset
REQ-028 With rst=1 at a rising edge, the state SHALL go to EMPTY.
REQ-029 Reset values SHALL be: out_valid=0, dec_out=0, occupancy=0, in_ready=1, tail cleared.
REQ-030 rst SHALL take priority over a simultaneous accept or pop; buffered words SHALL be discarded, including when reset is applied in state TWO.
REQ-031 No output SHALL change asynchronously on rst.

Verification
REQ-032 BIN_WIDTH=4, out_ready=1, accept bin_in=5 enable=1 -> the next cycle shows out_valid=1, dec_out=16'h0020.
REQ-033 Accept bin_in=15 enable=1, then bin_in=3 enable=0 -> dec_out is 16'h8000, then 16'h0000, each for one cycle with out_valid=1.
REQ-034 out_ready=0 and 3 words offered back-to-back (1, 2, 3) -> occupancy goes 1, 2; in_ready=0 after the 2nd accept; dec_out holds 16'h0002; the 3rd word is not accepted until a pop.
REQ-035 Occupancy 1, with accept and pop on the same edge -> occupancy stays 1, and dec_out takes the new word's one-hot value.
REQ-036 Occupancy 2, assert rst for one cycle -> the following cycle shows out_valid=0, dec_out=0, occupancy=0, in_ready=1; the old words never appear.
REQ-037 Random in_valid/out_ready over 10000 cycles for BIN_WIDTH=1, 4, 8 -> the output stream equals the scoreboarded input stream, and dec_out is always one-hot or zero.
